// File: rtl/pet_pkg.sv
// Shared definitions for the pet stat engine front end: action codes,
// scheduler state encoding and the round-robin pick helper.
package pet_pkg;

    localparam int unsigned NUM_ACT = 4;

    typedef enum logic [1:0] {
        ACT_FEED = 2'd0,
        ACT_REST = 2'd1,
        ACT_PLAY = 2'd2,
        ACT_HEAL = 2'd3
    } act_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } sched_state_e;

    // First set request at or after ptr, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [NUM_ACT-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_ACT; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pet_cooldown_timer.sv
// Single-channel cooldown: loaded on issue, counts seconds down to zero.
module pet_cooldown_timer #(
    parameter int unsigned COOLDOWN_S = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic tick_i,
    output logic busy_o
);

    localparam int unsigned CW = $clog2(COOLDOWN_S + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Load has priority over a coincident tick; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(COOLDOWN_S);
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pet_action_scheduler.sv
// Turns raw action request levels into serialized valid/ready action
// transactions with edge capture, per-action cooldown and round-robin
// arbitration; also generates the shared one-second tick.
module pet_action_scheduler
    import pet_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50,
    parameter int unsigned COOLDOWN_S = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_feed,
    input  logic         req_rest,
    input  logic         req_play,
    input  logic         req_heal,
    input  logic         test_mode,
    input  logic         dead,
    output logic         act_valid,
    output logic [1:0]   act_id,
    input  logic         act_ready,
    output logic         sec_tick,
    output logic [3:0]   pending,
    output logic [3:0]   cooldown_busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]      presc_q, presc_d;
    logic               sec_tick_q, sec_tick_d;
    logic [NUM_ACT-1:0] req_now, prev_q, rise;
    logic [NUM_ACT-1:0] pending_q, pending_d;
    logic [NUM_ACT-1:0] load, busy;
    sched_state_e       state_q, state_d;
    logic [1:0]         act_id_q, act_id_d;
    logic [1:0]         ptr_q, ptr_d;
    logic               xfer;
    logic               block;

    assign req_now = {req_heal, req_play, req_rest, req_feed};
    assign rise    = req_now & ~prev_q;
    assign block   = test_mode | dead;

    // Free-running prescaler; the tick is registered one cycle after wrap count.
    always_comb begin
        sec_tick_d = (presc_q == PW'(TICK_DIV - 1));
        presc_d    = sec_tick_d ? '0 : presc_q + PW'(1);
    end

    // Scheduler next state: pick in IDLE, hold offer until accept or abort.
    always_comb begin
        state_d  = state_q;
        act_id_d = act_id_q;
        ptr_d    = ptr_q;
        xfer     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((pending_q != '0) && !block) begin
                    act_id_d = rr_pick(pending_q, ptr_q);
                    state_d  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (act_ready) begin
                    xfer    = 1'b1;
                    ptr_d   = act_id_q + 2'd1;
                    state_d = ST_IDLE;
                end else if (block) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Pending set from admissible rises; issued-channel clear and blocking win.
    always_comb begin
        pending_d = pending_q | (rise & ~busy);
        if (xfer) pending_d[act_id_q] = 1'b0;
        if (block) pending_d = '0;
    end

    assign load = xfer ? (NUM_ACT'(1) << act_id_q) : '0;

    // All scheduler registers; history resets high so held inputs need re-press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            prev_q     <= '1;
            pending_q  <= '0;
            state_q    <= ST_IDLE;
            act_id_q   <= '0;
            ptr_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            prev_q     <= req_now;
            pending_q  <= pending_d;
            state_q    <= state_d;
            act_id_q   <= act_id_d;
            ptr_q      <= ptr_d;
        end
    end

    for (genvar g = 0; g < NUM_ACT; g++) begin : g_cd
        pet_cooldown_timer #(.COOLDOWN_S(COOLDOWN_S)) u_cd (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[g]),
            .tick_i (sec_tick_q),
            .busy_o (busy[g])
        );
    end

    assign act_valid     = (state_q == ST_OFFER);
    assign act_id        = act_id_q;
    assign sec_tick      = sec_tick_q;
    assign pending       = pending_q;
    assign cooldown_busy = busy;

endmodule

// File: tb/tb_pet_action_scheduler.sv
// Bench for pet_action_scheduler: behavioural model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_pet_action_scheduler;

    localparam int TICK_DIV   = 4;
    localparam int COOLDOWN_S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_feed = 1'b0, req_rest = 1'b0, req_play = 1'b0, req_heal = 1'b0;
    logic       test_mode = 1'b0, dead = 1'b0, act_ready = 1'b0;
    logic       act_valid, sec_tick;
    logic [1:0] act_id;
    logic [3:0] pending, cooldown_busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pet_action_scheduler #(.TICK_DIV(TICK_DIV), .COOLDOWN_S(COOLDOWN_S)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_feed      (req_feed),
        .req_rest      (req_rest),
        .req_play      (req_play),
        .req_heal      (req_heal),
        .test_mode     (test_mode),
        .dead          (dead),
        .act_valid     (act_valid),
        .act_id        (act_id),
        .act_ready     (act_ready),
        .sec_tick      (sec_tick),
        .pending       (pending),
        .cooldown_busy (cooldown_busy)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_presc;
    bit       m_tick;
    bit [3:0] m_pend;
    int       m_cd[4];
    bit [3:0] m_prev;
    int       m_ptr;
    bit       m_offer;
    int       m_id;
    bit       m_ok = 1'b0;

    always @(posedge clk) begin : model
        bit [3:0] req, rise, np;
        int       ncd[4];
        bit       blk, xfer;
        req = {req_heal, req_play, req_rest, req_feed};
        if (!rst) begin
            m_presc = 0; m_tick = 0; m_pend = 0; m_prev = 4'hf;
            m_ptr = 0; m_offer = 0; m_id = 0; m_ok = 1;
            for (int c = 0; c < 4; c++) m_cd[c] = 0;
        end else begin
            blk  = test_mode || dead;
            xfer = m_offer && act_ready;
            rise = req & ~m_prev;
            m_prev = req;
            np = m_pend;
            for (int c = 0; c < 4; c++) if (rise[c] && m_cd[c] == 0) np[c] = 1;
            if (xfer) np[m_id] = 0;
            if (blk) np = 0;
            for (int c = 0; c < 4; c++) begin
                if (xfer && c == m_id)        ncd[c] = COOLDOWN_S;
                else if (m_tick && m_cd[c] > 0) ncd[c] = m_cd[c] - 1;
                else                          ncd[c] = m_cd[c];
            end
            if (m_offer) begin
                if (xfer) begin
                    m_ptr = (m_id + 1) % 4;
                    m_offer = 0;
                end else if (blk) begin
                    m_offer = 0;
                end
            end else if (m_pend != 0 && !blk) begin
                for (int k = 3; k >= 0; k--) if (m_pend[(m_ptr + k) % 4]) m_id = (m_ptr + k) % 4;
                m_offer = 1;
            end
            m_tick  = (m_presc == TICK_DIV - 1);
            m_presc = (m_presc + 1) % TICK_DIV;
            m_pend  = np;
            for (int c = 0; c < 4; c++) m_cd[c] = ncd[c];
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin : compare
        bit [3:0] mb;
        if (m_ok) begin
            for (int c = 0; c < 4; c++) mb[c] = (m_cd[c] != 0);
            chk("model act_valid", 8'(act_valid), 8'(m_offer));
            chk("model act_id", 8'(act_id), 8'(m_id));
            chk("model sec_tick", 8'(sec_tick), 8'(m_tick));
            chk("model pending", 8'(pending), 8'(m_pend));
            chk("model cooldown_busy", 8'(cooldown_busy), 8'(mb));
        end
    end

    task automatic wait_busy_clear(input int budget);
        int i = 0;
        while (cooldown_busy != 4'h0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait busy clear", 8'(cooldown_busy), 8'h0);
    endtask

    task automatic wait_tick(input int budget);
        int i = 0;
        while (!sec_tick && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("wait sec_tick", 8'(sec_tick), 8'h1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int ticks, guard, per;

        // 1: held through reset needs release and re-press
        req_feed = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset valid", 8'(act_valid), 8'h0);
        chk("reset tick", 8'(sec_tick), 8'h0);
        chk("reset busy", 8'(cooldown_busy), 8'h0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("held pending", 8'(pending), 8'h0);
        chk("held valid", 8'(act_valid), 8'h0);
        req_feed = 1'b0;
        @(negedge clk);
        req_feed = 1'b1;
        @(negedge clk);
        chk("press pending", 8'(pending), 8'h1);
        @(negedge clk);
        chk("press valid", 8'(act_valid), 8'h1);
        chk("press id", 8'(act_id), 8'h0);

        // 5: stall then abort by test_mode
        repeat (10) begin
            @(negedge clk);
            chk("stall valid", 8'(act_valid), 8'h1);
            chk("stall id", 8'(act_id), 8'h0);
        end
        test_mode = 1'b1;
        @(negedge clk);
        chk("abort valid", 8'(act_valid), 8'h0);
        chk("abort pending", 8'(pending), 8'h0);
        chk("abort busy", 8'(cooldown_busy), 8'h0);
        test_mode = 1'b0;
        req_feed  = 1'b0;
        @(negedge clk);

        // 2: single play pulse with ready held high
        act_ready = 1'b1;
        req_play  = 1'b1;
        @(negedge clk);
        req_play = 1'b0;
        @(negedge clk);
        chk("play valid", 8'(act_valid), 8'h1);
        chk("play id", 8'(act_id), 8'h2);
        @(negedge clk);
        chk("play one-cycle valid", 8'(act_valid), 8'h0);
        chk("play busy set", 8'(cooldown_busy[2]), 8'h1);
        ticks = 0;
        guard = 0;
        while (ticks < 2 && guard < 40) begin
            if (sec_tick) ticks++;
            if (ticks < 2) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("play ticks seen", 8'(ticks), 8'h2);
        chk("play busy at 2nd tick", 8'(cooldown_busy[2]), 8'h1);
        @(negedge clk);
        chk("play busy after 2nd tick", 8'(cooldown_busy[2]), 8'h0);
        wait_tick(20);
        per = 0;
        do begin
            @(negedge clk);
            per++;
        end while (!sec_tick && per < 20);
        chk("tick period", 8'(per), 8'h4);

        // 3: simultaneous rise from pointer 0 after a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        {req_heal, req_play, req_rest, req_feed} = 4'hf;
        @(negedge clk);
        chk("all pending", 8'(pending), 8'hf);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr valid", 8'(act_valid), 8'h1);
            chk("rr id", 8'(act_id), 8'(k));
            @(negedge clk);
            chk("rr bubble", 8'(act_valid), 8'h0);
        end
        {req_heal, req_play, req_rest, req_feed} = 4'h0;
        wait_busy_clear(40);
        req_feed = 1'b1;
        req_heal = 1'b1;
        @(negedge clk);
        chk("feed+heal pending", 8'(pending), 8'h9);
        @(negedge clk);
        chk("feed+heal first", 8'(act_id), 8'h0);
        chk("feed+heal first valid", 8'(act_valid), 8'h1);
        @(negedge clk);
        chk("feed+heal bubble", 8'(act_valid), 8'h0);
        req_feed = 1'b0;

        // 4: re-press during cooldown is dropped
        @(negedge clk);
        chk("feed+heal second", 8'(act_id), 8'h3);
        chk("feed busy before re-press", 8'(cooldown_busy[0]), 8'h1);
        req_feed = 1'b1;
        @(negedge clk);
        chk("re-press dropped", 8'(pending[0]), 8'h0);
        guard = 0;
        while (cooldown_busy[0] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("feed busy cleared", 8'(cooldown_busy[0]), 8'h0);
        req_feed = 1'b0;
        @(negedge clk);
        req_feed = 1'b1;
        @(negedge clk);
        chk("re-press accepted", 8'(pending[0]), 8'h1);
        @(negedge clk);
        chk("re-press issued", 8'(act_valid), 8'h1);
        chk("re-press id", 8'(act_id), 8'h0);
        req_feed = 1'b0;
        req_heal = 1'b0;

        // dead blocks a rise outright
        wait_busy_clear(40);
        dead     = 1'b1;
        req_play = 1'b1;
        @(negedge clk);
        chk("dead drops rise", 8'(pending), 8'h0);
        dead     = 1'b0;
        req_play = 1'b0;
        @(negedge clk);

        // 6: reset during an offer records nothing
        act_ready = 1'b0;
        req_rest  = 1'b1;
        @(negedge clk);
        chk("rest pending", 8'(pending), 8'h2);
        @(negedge clk);
        chk("rest offered", 8'(act_valid), 8'h1);
        chk("rest id", 8'(act_id), 8'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid-offer reset valid", 8'(act_valid), 8'h0);
        chk("mid-offer reset id", 8'(act_id), 8'h0);
        chk("mid-offer reset tick", 8'(sec_tick), 8'h0);
        chk("mid-offer reset pending", 8'(pending), 8'h0);
        chk("mid-offer reset busy", 8'(cooldown_busy), 8'h0);
        rst      = 1'b1;
        req_rest = 1'b0;
        repeat (3) @(negedge clk);
        chk("post-reset busy", 8'(cooldown_busy), 8'h0);
        chk("post-reset valid", 8'(act_valid), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
